uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Packet-granular round-robin arbiter that lets up to N_REQ requesters share the write port of the UART transmit FIFO. It sits in front of the UART top level and drives its `w_data`/`wr_uart` inputs while observing `tx_full`. Once a requester is granted, it keeps the UART until it sends its last byte, so messages are never interleaved. A watchdog releases the grant if the owner stalls mid-packet.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DBIT`, 8: data bits per byte; must match the UART `DBIT`.
- `TIMEOUT`, 1023: number of consecutive owner-idle cycles that aborts a packet. Range 1..65535.
- `clk` in 1: system clock. The whole block is a single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester byte valid.
- `req_data` in N_REQ*DBIT: per-requester byte. Requester i uses bits [i*DBIT +: DBIT].
- `req_last` in N_REQ: marks the final byte of a packet. Qualified by valid.
- `req_ready` out N_REQ: byte accepted when valid & ready are both high.
- `w_data` out DBIT: to UART TX FIFO write data.
- `wr_uart` out 1: to UART TX FIFO write strobe.
- `tx_full` in 1: from UART TX FIFO full flag.
- `grant_id` out clog2(N_REQ): index of the current owner. Held at the last owner while IDLE.
- `busy` out 1: high while a packet is owned.
- `timeout_err` out 1: one-cycle pulse when a packet is aborted.

## Operation
- Two-state FSM: IDLE and OWN.
- **IDLE**
  - All `req_ready` are 0.
  - If any `req_valid` is high, select the first requester with valid high, searching from (`last_grant`+1) mod N_REQ upward with wrap.
  - Register the selection into `grant_id`, set `busy`, and go to OWN at the next edge.
  - No byte is accepted in the arbitration cycle.
- **OWN**
  - `req_ready[grant_id]` = ~`tx_full`. All other ready bits are 0.
  - Accept = `req_valid[grant_id]` & `req_ready[grant_id]`.
  - `wr_uart` = accept (combinational).
  - `w_data` = `req_data` slice of `grant_id` (combinational). Its value is don't-care when `wr_uart` is 0.
  - Accept with `req_last` high: `last_grant` <= `grant_id`, then IDLE at the next edge.
  - Watchdog counter `idle_cnt`, 16 bits:
    - Clears on entry to OWN and on every accept.
    - Increments in each OWN cycle in which `req_valid[grant_id]` is 0.
    - Holds while the owner is valid but stalled by `tx_full`. Backpressure is never a timeout.
  - Abort: when `idle_cnt` reaches TIMEOUT-1 and the owner is still not valid, pulse `timeout_err`, set `last_grant` <= `grant_id`, and go to IDLE. No byte is written in the abort cycle.
- Fairness: the finishing or aborted owner has the lowest priority in the next arbitration.
- Non-owner requesters may assert valid at any time. They must hold data and last stable until accepted (AXI-style rule). The arbiter does not check this.
- Simultaneous events:
  - Accept and timeout cannot coincide, because accept requires valid.
  - A `tx_full` rising in the same cycle as valid blocks that byte, because ready is combinational from `tx_full`.
  - A single-byte packet (valid with last on the first byte) occupies exactly one OWN cycle when `tx_full` is 0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM in IDLE.
  - `grant_id`=0, `last_grant`=N_REQ-1, so requester 0 has top priority after reset.
  - `busy`=0, `timeout_err`=0, `idle_cnt`=0.
  - `req_ready`=0, `wr_uart`=0.
- Reset mid-packet drops ownership immediately. No partial-packet recovery is attempted. The UART FIFO keeps the bytes already written unless it is reset too.
- Grant latency: 1 cycle from valid in IDLE to the first possible accept.
- Throughput: 1 byte per cycle while the owner is valid and `tx_full`=0.
- Packet turnaround: the last-byte accept at cycle t gives IDLE at t+1, arbitration at t+1, and the next owner's first accept at t+2.
- The last-byte accept drops `busy` at the following edge.
- `timeout_err` is registered. It is high for the single cycle after the abort decision, coincident with IDLE.
- `grant_id` and `busy` are registered. `req_ready`, `wr_uart` and `w_data` are combinational from state, `tx_full` and the request inputs.

## Test plan
- **Single requester.** Reset, then requester 2 sends 0x41, 0x42, 0x43 with last on 0x43 and `tx_full`=0 → `grant_id`=2 one cycle after valid; `wr_uart` high for 3 consecutive cycles with `w_data` 0x41, 0x42, 0x43; `busy` falls the cycle after 0x43.
- **Round-robin.** Requesters 0, 1 and 3 all hold 2-byte packets from reset → grant order 0, 1, 3, then 0 again. No bytes from different packets are interleaved. Each handover leaves exactly one gap cycle without `wr_uart`.
- **Backpressure.** Requester 1 owns, `tx_full` is forced high for 2000 cycles (> TIMEOUT) mid-packet → `req_ready[1]`=0 and `wr_uart`=0 throughout; no `timeout_err`; the packet resumes when `tx_full` falls.
- **Timeout.** TIMEOUT=16. Requester 0 sends 1 byte without last, then drops valid → `timeout_err` pulses once 16 owner-idle cycles later; `busy` falls. Requester 1, already waiting, is granted next even though requester 0 reasserts.
- **Reset mid-packet.** Assert `reset_n`=0 asynchronously during byte 2 of a 4-byte packet → `wr_uart`, `req_ready` and `busy` go to 0 without a clock edge; after release, requester 0 wins the first arbitration.
- **Single-byte packets.** 1-byte packets back-to-back from all four requesters → exactly 4 writes in 8 cycles, in order 0, 1, 2, 3, and `w_data` matches each requester's byte.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the UART TX FIFO write port.
// An owner keeps the FIFO until its last byte; a watchdog frees a stalled owner.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 1023,
  localparam int GW     = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*DBIT-1:0] req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  output logic [DBIT-1:0]       w_data,
  output logic                  wr_uart,
  input  logic                  tx_full,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic                  timeout_err
);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [15:0]   idle_cnt_q, idle_cnt_d;
  logic          tmo_q, tmo_d;

  logic [GW-1:0] pick;
  logic          pick_vld;
  logic          own_valid;
  logic          own_last;
  logic          accept;
  logic          abort;
  int            idx;

  // Walk from the lowest-priority slot (last owner) up to last+1 so the
  // nearest valid requester after the last owner is the one that sticks.
  always_comb begin
    pick     = last_q;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last_q) + k) % N_REQ;
      if (req_valid[idx]) begin
        pick     = GW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign own_valid = req_valid[grant_q];
  assign own_last  = req_last[grant_q];
  assign accept    = (state_q == S_OWN) && own_valid && !tx_full;
  assign abort     = (state_q == S_OWN) && !own_valid && (idle_cnt_q == TMO_LAST);

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (state_q == S_OWN) && (grant_q == GW'(gi)) && !tx_full;
    end
  endgenerate

  assign wr_uart     = accept;
  assign w_data      = req_data[int'(grant_q)*DBIT +: DBIT];
  assign grant_id    = grant_q;
  assign busy        = (state_q == S_OWN);
  assign timeout_err = tmo_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    idle_cnt_d = idle_cnt_q;
    tmo_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d    = pick;
          idle_cnt_d = 16'd0;
          state_d    = S_OWN;
        end
      end
      S_OWN: begin
        if (accept) begin
          idle_cnt_d = 16'd0;
          if (own_last) begin
            last_d  = grant_q;
            state_d = S_IDLE;
          end
        end else if (abort) begin
          tmo_d      = 1'b1;
          last_d     = grant_q;
          idle_cnt_d = 16'd0;
          state_d    = S_IDLE;
        end else if (!own_valid) begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
        // Owner valid but blocked by tx_full: counter holds.
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      last_q     <= GW'(N_REQ - 1);
      idle_cnt_q <= 16'd0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      idle_cnt_q <= idle_cnt_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte sources feed the DUT,
// expected writes are queued by the stimulus and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int DBIT    = 8;
  localparam int TIMEOUT = 16;
  localparam int GW      = 2;

  logic                  clk;
  logic                  reset_n;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*DBIT-1:0] req_data;
  logic [N_REQ-1:0]      req_last;
  logic [N_REQ-1:0]      req_ready;
  logic [DBIT-1:0]       w_data;
  logic                  wr_uart;
  logic                  tx_full;
  logic [GW-1:0]         grant_id;
  logic                  busy;
  logic                  timeout_err;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DBIT(DBIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .w_data(w_data), .wr_uart(wr_uart),
    .tx_full(tx_full), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [DBIT:0] ent_t;   // {last, data}
  typedef struct { int id; int data; int gap; } exp_t;

  ent_t src [N_REQ][$];
  exp_t exp_q [$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  task automatic push_exp(input int id, input int data, input int gap);
    exp_t e;
    e.id = id; e.data = data; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Requester sources: present the head byte, pop it once accepted.
  initial begin
    logic [N_REQ-1:0] acc;
    ent_t tmp;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (acc[i] && src[i].size() > 0) tmp = src[i].pop_front();
        if (src[i].size() > 0) begin
          req_valid[i]                = 1'b1;
          req_data[i*DBIT +: DBIT]    = src[i][0][DBIT-1:0];
          req_last[i]                 = src[i][0][DBIT];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: every FIFO write must match the head of the scoreboard.
  int   cyc    = 0;
  int   last_wr = -1;
  exp_t mon_e;
  always @(negedge clk) begin
    cyc++;
    if (wr_uart) begin
      $display("write  t=%0d  grant=%0d  data=0x%02h", cyc, grant_id, w_data);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got data 0x%0h from %0d, expected no write", w_data, grant_id);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_owner", int'(grant_id), mon_e.id);
        chk("write_data", int'(w_data), mon_e.data);
        if (mon_e.gap >= 0 && last_wr >= 0) chk("write_gap", cyc - last_wr - 1, mon_e.gap);
      end
      last_wr = cyc;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic wait_wr(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!wr_uart && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(nm, int'(wr_uart), 1);
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk(nm, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int bad;
    int wrs;
    reset_n = 1'b0;
    tx_full = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_wr", int'(wr_uart), 0);
    chk("rst_tmo", int'(timeout_err), 0);

    // Single requester: 3-byte packet from requester 2
    @(posedge clk);
    #2;
    src[2].push_back(9'h041); src[2].push_back(9'h042); src[2].push_back(9'h143);
    push_exp(2, 8'h41, -1); push_exp(2, 8'h42, 0); push_exp(2, 8'h43, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_arb_busy", int'(busy), 0);
    @(negedge clk);
    chk("t1_grant", int'(grant_id), 2);
    chk("t1_busy", int'(busy), 1);
    @(negedge clk);
    @(negedge clk);
    chk("t1_busy_last", int'(busy), 1);
    @(negedge clk);
    chk("t1_busy_drop", int'(busy), 0);
    chk("t1_grant_held", int'(grant_id), 2);
    drain("t1_drain");

    // Round-robin between requesters 0, 1, 3 with a second packet from 0
    do_reset();
    @(posedge clk);
    #2;
    src[0].push_back(9'h010); src[0].push_back(9'h111);
    src[0].push_back(9'h012); src[0].push_back(9'h113);
    src[1].push_back(9'h020); src[1].push_back(9'h121);
    src[3].push_back(9'h030); src[3].push_back(9'h131);
    push_exp(0, 8'h10, -1); push_exp(0, 8'h11, 0);
    push_exp(1, 8'h20, 1);  push_exp(1, 8'h21, 0);
    push_exp(3, 8'h30, 1);  push_exp(3, 8'h31, 0);
    push_exp(0, 8'h12, 1);  push_exp(0, 8'h13, 0);
    drain("t2_drain");

    // Backpressure longer than the watchdog must not abort
    @(posedge clk);
    #2;
    src[1].push_back(9'h0B1); src[1].push_back(9'h0B2); src[1].push_back(9'h1B3);
    push_exp(1, 8'hB1, -1); push_exp(1, 8'hB2, 2000); push_exp(1, 8'hB3, 0);
    wait_wr("t3_first_write");
    @(posedge clk);
    #1 tx_full = 1'b1;
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (req_ready != '0 || wr_uart || timeout_err || !busy) bad++;
    end
    chk("t3_stall_cycles_bad", bad, 0);
    @(posedge clk);
    #1 tx_full = 1'b0;
    drain("t3_drain");

    // Watchdog abort; waiting requester 1 wins over re-asserting requester 0
    do_reset();
    @(posedge clk);
    #2;
    src[0].push_back(9'h055);
    src[1].push_back(9'h066); src[1].push_back(9'h167);
    push_exp(0, 8'h55, -1); push_exp(1, 8'h66, 17); push_exp(1, 8'h67, 0);
    push_exp(0, 8'h77, 1);
    wait_wr("t4_first_write");
    bad = 0;
    for (int j = 1; j <= TIMEOUT; j++) begin
      @(negedge clk);
      if (timeout_err || !busy) bad++;
    end
    chk("t4_early_abort", bad, 0);
    src[0].push_back(9'h177);
    @(negedge clk);
    chk("t4_tmo_pulse", int'(timeout_err), 1);
    chk("t4_busy_drop", int'(busy), 0);
    @(negedge clk);
    chk("t4_tmo_clear", int'(timeout_err), 0);
    chk("t4_next_grant", int'(grant_id), 1);
    chk("t4_next_busy", int'(busy), 1);
    drain("t4_drain");

    // Asynchronous reset during byte 2 of a 4-byte packet
    @(posedge clk);
    #2;
    src[1].push_back(9'h081); src[1].push_back(9'h082);
    src[1].push_back(9'h083); src[1].push_back(9'h184);
    src[0].push_back(9'h190);
    push_exp(1, 8'h81, -1); push_exp(0, 8'h90, -1);
    push_exp(1, 8'h82, 1);  push_exp(1, 8'h83, 0); push_exp(1, 8'h84, 0);
    wait_wr("t5_first_write");
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_wr", int'(wr_uart), 0);
    chk("t5_rst_ready", int'(req_ready), 0);
    chk("t5_rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_first_grant", int'(grant_id), 0);
    chk("t5_first_busy", int'(busy), 1);
    drain("t5_drain");

    // Back-to-back single-byte packets from all requesters
    do_reset();
    @(posedge clk);
    #2;
    for (int i = 0; i < N_REQ; i++) begin
      src[i].push_back(ent_t'(9'h100 | (8'hA0 + i)));
      push_exp(i, 8'hA0 + i, (i == 0) ? -1 : 1);
    end
    @(negedge clk);
    wrs = 0;
    repeat (8) begin
      @(negedge clk);
      if (wr_uart) wrs++;
    end
    chk("t6_write_count", wrs, 4);
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
